// File: rtl/sm3_pad_core_p_if.sv
// sm3_pad_core_p_if: message-in / padded-out stream bundle for the SM3 padder
interface sm3_pad_core_p_if #(
  parameter int DW = 64
);
  localparam int BW = DW / 8;
  logic [DW-1:0] msg_inpt_d_i;
  logic [BW-1:0] msg_inpt_vld_byte_i;
  logic          msg_inpt_vld_i;
  logic          msg_inpt_lst_i;
  logic          msg_inpt_rdy_o;
  logic [DW-1:0] pad_otpt_d_o;
  logic          pad_otpt_vld_o;
  logic          pad_otpt_rdy_i;
  logic          pad_otpt_blk_lst_o;
  logic          pad_otpt_lst_o;
  modport slave (
    input  msg_inpt_d_i, msg_inpt_vld_byte_i, msg_inpt_vld_i, msg_inpt_lst_i, pad_otpt_rdy_i,
    output msg_inpt_rdy_o, pad_otpt_d_o, pad_otpt_vld_o, pad_otpt_blk_lst_o, pad_otpt_lst_o
  );
  modport master (
    output msg_inpt_d_i, msg_inpt_vld_byte_i, msg_inpt_vld_i, msg_inpt_lst_i, pad_otpt_rdy_i,
    input  msg_inpt_rdy_o, pad_otpt_d_o, pad_otpt_vld_o, pad_otpt_blk_lst_o, pad_otpt_lst_o
  );
endinterface

// File: rtl/sm3_pad_core_p.sv
// sm3_pad_core_p: SM3 message padder, byte-granular stream in, 512-bit-aligned padded stream out
module sm3_pad_core_p #(
  parameter int DW = 64
) (
  input logic clk,
  input logic rst_n,
  sm3_pad_core_p_if.slave bus
);
  localparam int BW = DW / 8;
  localparam int BPB = 512 / DW;
  localparam int PW = $clog2(BPB);
  typedef enum logic [1:0] {IDLE, DATA, PAD} st_t;
  st_t st_q;
  logic [60:0] len_q, len_d;
  logic [PW-1:0] pos_q;
  logic pend_q, fin_q, fin_d, done_d;
  logic [DW-1:0] d_q, beat_d;
  logic vld_q, blk_q, lst_q;
  logic slot_free, in_xfer, ld, lst;
  logic [63:0] lb;
  int n, nb, o;
  assign lst = bus.msg_inpt_lst_i;
  assign slot_free = !vld_q || bus.pad_otpt_rdy_i;
  assign bus.msg_inpt_rdy_o = slot_free && st_q != PAD;
  assign in_xfer = bus.msg_inpt_vld_i && bus.msg_inpt_rdy_o;
  assign ld = in_xfer || (st_q == PAD && slot_free);
  assign bus.pad_otpt_d_o = d_q;
  assign bus.pad_otpt_vld_o = vld_q;
  assign bus.pad_otpt_blk_lst_o = blk_q;
  assign bus.pad_otpt_lst_o = lst_q;
  // Build the next output beat: message bytes, the 0x80 marker, length bytes in the final block's tail, else zero
  always_comb begin
    n = 0;
    for (int j = 0; j < BW; j++) n += int'(bus.msg_inpt_vld_byte_i[j]);
    nb = st_q == PAD ? 0 : !lst ? BW : n;
    len_d = st_q == PAD ? len_q : len_q + 61'(nb);
    fin_d = st_q == PAD ? fin_q : len_d[5:0] <= 6'd55;
    lb = {len_d, 3'b000};
    done_d = fin_d && pos_q == PW'(BPB - 1) && (st_q == PAD || (lst && n < BW));
    beat_d = '0;
    o = 0;
    for (int j = 0; j < BW; j++) begin
      o = int'(pos_q) * BW + j;
      beat_d[DW-1-8*j -: 8] = j < nb ? bus.msg_inpt_d_i[DW-1-8*j -: 8] :
                              (j == nb && (st_q != PAD || pend_q)) ? 8'h80 :
                              (fin_d && o >= 56) ? lb[63-8*(o%8) -: 8] : 8'h00;
    end
  end
  // Message-state FSM and the single registered output slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      len_q <= '0;
      pos_q <= '0;
      pend_q <= 1'b0;
      fin_q <= 1'b0;
      d_q <= '0;
      vld_q <= 1'b0;
      blk_q <= 1'b0;
      lst_q <= 1'b0;
    end else if (ld) begin
      d_q <= beat_d;
      vld_q <= 1'b1;
      blk_q <= pos_q == PW'(BPB - 1);
      lst_q <= done_d;
      pos_q <= pos_q + PW'(1);
      if (done_d) begin
        st_q <= IDLE;
        len_q <= '0;
        pos_q <= '0;
        pend_q <= 1'b0;
        fin_q <= 1'b0;
      end else if (st_q == PAD) begin
        pend_q <= 1'b0;
        if (pos_q == PW'(BPB - 1)) fin_q <= 1'b1;
      end else if (lst) begin
        st_q <= PAD;
        len_q <= len_d;
        fin_q <= fin_d;
        pend_q <= n == BW;
      end else begin
        st_q <= DATA;
        len_q <= len_d;
      end
    end else if (bus.pad_otpt_rdy_i) begin
      vld_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sm3_pad_core_p.sv
// tb_sm3_pad_core_p: directed scoreboard bench over DW=32/64/128 padder instances
module tb_sm3_pad_core_p;
  logic clk, rst_n, bp;
  int checks, errs;
  logic [129:0] q32[$], q64[$], q128[$];
  logic st32;
  logic [33:0] h32;

  sm3_pad_core_p_if #(.DW(32))  i32();
  sm3_pad_core_p_if #(.DW(64))  i64();
  sm3_pad_core_p_if #(.DW(128)) i128();
  sm3_pad_core_p #(.DW(32))  u32 (.clk(clk), .rst_n(rst_n), .bus(i32.slave));
  sm3_pad_core_p #(.DW(64))  u64 (.clk(clk), .rst_n(rst_n), .bus(i64.slave));
  sm3_pad_core_p #(.DW(128)) u128(.clk(clk), .rst_n(rst_n), .bus(i128.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    i32.pad_otpt_rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i32.pad_otpt_rdy_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(string nm, logic [129:0] got, logic [129:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %h required %h", nm, got, exp);
    end
  endtask

  task automatic push(int w, logic [127:0] d, logic b, logic l);
    if (w == 0) q32.push_back({d, b, l});
    else if (w == 1) q64.push_back({d, b, l});
    else q128.push_back({d, b, l});
  endtask

  task automatic zeros(int w, int c);
    repeat (c) push(w, '0, 1'b0, 1'b0);
  endtask

  function automatic int qsize(int w);
    return w == 0 ? q32.size() : w == 1 ? q64.size() : q128.size();
  endfunction

  function automatic logic in_rdy(int w);
    return w == 0 ? i32.msg_inpt_rdy_o : w == 1 ? i64.msg_inpt_rdy_o : i128.msg_inpt_rdy_o;
  endfunction

  function automatic logic [4:0] rview(int w);
    if (w == 0) return {i32.pad_otpt_vld_o, i32.pad_otpt_blk_lst_o, i32.pad_otpt_lst_o, i32.msg_inpt_rdy_o, |i32.pad_otpt_d_o};
    if (w == 1) return {i64.pad_otpt_vld_o, i64.pad_otpt_blk_lst_o, i64.pad_otpt_lst_o, i64.msg_inpt_rdy_o, |i64.pad_otpt_d_o};
    return {i128.pad_otpt_vld_o, i128.pad_otpt_blk_lst_o, i128.pad_otpt_lst_o, i128.msg_inpt_rdy_o, |i128.pad_otpt_d_o};
  endfunction

  task automatic drive(int w, logic [127:0] d, logic [15:0] m, logic v, logic l);
    if (w == 0) begin
      i32.msg_inpt_d_i = d[31:0]; i32.msg_inpt_vld_byte_i = m[3:0]; i32.msg_inpt_vld_i = v; i32.msg_inpt_lst_i = l;
    end else if (w == 1) begin
      i64.msg_inpt_d_i = d[63:0]; i64.msg_inpt_vld_byte_i = m[7:0]; i64.msg_inpt_vld_i = v; i64.msg_inpt_lst_i = l;
    end else begin
      i128.msg_inpt_d_i = d; i128.msg_inpt_vld_byte_i = m; i128.msg_inpt_vld_i = v; i128.msg_inpt_lst_i = l;
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int w, logic [127:0] d, logic [15:0] m, logic l);
    int t = 0;
    drive(w, d, m, 1'b1, l);
    @(negedge clk);
    while (!in_rdy(w) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_rdy(w)) begin
      checks++;
      errs++;
      $display("FAIL send_w%0d input ready never seen, got 0 required 1", w);
    end
    sync();
    drive(w, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain(int w);
    int t = 0;
    while (qsize(w) != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (qsize(w) != 0) begin
      errs++;
      $display("FAIL drain_w%0d outstanding %0d beats required 0", w, qsize(w));
    end
    repeat (3) @(negedge clk);
    sync();
  endtask

  task automatic abc_expect();
    push(0, 32'h61626380, 1'b0, 1'b0);
    zeros(0, 14);
    push(0, 32'h00000018, 1'b1, 1'b1);
  endtask

  always @(negedge clk) begin
    if (i32.pad_otpt_vld_o && i32.pad_otpt_rdy_i) begin
      if (q32.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL w32_extra got %h required no beat", i32.pad_otpt_d_o);
      end else chk("w32_beat", {96'h0, i32.pad_otpt_d_o, i32.pad_otpt_blk_lst_o, i32.pad_otpt_lst_o}, q32.pop_front());
    end
    if (st32) chk("w32_hold", {95'h0, i32.pad_otpt_vld_o, i32.pad_otpt_d_o, i32.pad_otpt_blk_lst_o, i32.pad_otpt_lst_o}, {95'h0, 1'b1, h32});
    if (i32.pad_otpt_vld_o && !i32.pad_otpt_rdy_i) begin
      chk("w32_inrdy_stall", {129'h0, i32.msg_inpt_rdy_o}, 130'h0);
      st32 <= 1'b1;
      h32 <= {i32.pad_otpt_d_o, i32.pad_otpt_blk_lst_o, i32.pad_otpt_lst_o};
    end else st32 <= 1'b0;
  end

  always @(negedge clk) begin
    if (i64.pad_otpt_vld_o && i64.pad_otpt_rdy_i) begin
      if (q64.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL w64_extra got %h required no beat", i64.pad_otpt_d_o);
      end else chk("w64_beat", {64'h0, i64.pad_otpt_d_o, i64.pad_otpt_blk_lst_o, i64.pad_otpt_lst_o}, q64.pop_front());
    end
  end

  always @(negedge clk) begin
    if (i128.pad_otpt_vld_o && i128.pad_otpt_rdy_i) begin
      if (q128.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL w128_extra got %h required no beat", i128.pad_otpt_d_o);
      end else chk("w128_beat", {i128.pad_otpt_d_o, i128.pad_otpt_blk_lst_o, i128.pad_otpt_lst_o}, q128.pop_front());
    end
  end

  initial begin
    checks = 0;
    errs = 0;
    bp = 1'b0;
    st32 = 1'b0;
    h32 = '0;
    rst_n = 1'b0;
    i64.pad_otpt_rdy_i = 1'b1;
    i128.pad_otpt_rdy_i = 1'b1;
    for (int w = 0; w < 3; w++) drive(w, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int w = 0; w < 3; w++) chk($sformatf("reset_w%0d", w), {125'h0, rview(w)}, {125'h0, 5'b00010});
    rst_n = 1'b1;
    sync();
    // "abc" on 32-bit
    abc_expect();
    send(0, 32'h61626300, 16'h000E, 1'b1);
    drain(0);
    // 55-byte then 56-byte messages back to back on 64-bit
    for (int i = 0; i < 6; i++) push(1, {8{8'(i + 1)}}, 1'b0, 1'b0);
    push(1, 64'h0707070707070780, 1'b0, 1'b0);
    push(1, 64'h00000000000001B8, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) push(1, {8{8'(16 + i)}}, 1'b0, 1'b0);
    push(1, 64'h8000000000000000, 1'b1, 1'b0);
    zeros(1, 7);
    push(1, 64'h00000000000001C0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) send(1, {8{8'(i + 1)}}, 16'h00FF, 1'b0);
    send(1, 64'h07070707070707FF, 16'h00FE, 1'b1);
    for (int i = 0; i < 7; i++) send(1, {8{8'(16 + i)}}, 16'h00FF, i == 6);
    drain(1);
    // zero-length, then a 52-byte message whose tail beat carries the length on 128-bit
    push(2, 128'h80000000_00000000_00000000_00000000, 1'b0, 1'b0);
    zeros(2, 2);
    push(2, '0, 1'b1, 1'b1);
    push(2, {16{8'hA1}}, 1'b0, 1'b0);
    push(2, {16{8'hB2}}, 1'b0, 1'b0);
    push(2, {16{8'hC3}}, 1'b0, 1'b0);
    push(2, 128'hDDDDDDDD_80000000_00000000_000001A0, 1'b1, 1'b1);
    send(2, '0, 16'h0000, 1'b1);
    send(2, {16{8'hA1}}, 16'hFFFF, 1'b0);
    send(2, {16{8'hB2}}, 16'hFFFF, 1'b0);
    send(2, {16{8'hC3}}, 16'hFFFF, 1'b0);
    send(2, {16{8'hDD}}, 16'hF000, 1'b1);
    drain(2);
    // 64-byte message on 32-bit under random back-pressure
    bp = 1'b1;
    for (int i = 0; i < 16; i++) push(0, {4{8'(i + 1)}}, i == 15, 1'b0);
    push(0, 32'h80000000, 1'b0, 1'b0);
    zeros(0, 14);
    push(0, 32'h00000200, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) send(0, {4{8'(i + 1)}}, 16'h000F, i == 15);
    drain(0);
    bp = 1'b0;
    sync();
    // reset while padding, then a clean "abc"
    abc_expect();
    send(0, 32'h61626300, 16'h000E, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    q32.delete();
    rst_n = 1'b0;
    #1;
    chk("reset_mid_pad", {125'h0, rview(0)}, {125'h0, 5'b00010});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_no_partial", {129'h0, i32.pad_otpt_vld_o}, 130'h0);
    sync();
    abc_expect();
    send(0, 32'h61626300, 16'h000E, 1'b1);
    drain(0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule

// File: doc/sm3_pad_core_p.md
Name: sm3_pad_core_p

Overview:
Parametrised SM3 message padder, DW-bit datapath (32/64/128).
- Accepts a byte-granular message stream under valid/ready.
- Emits the padded stream: message, then 0x80, then zeros, then the 64-bit big-endian bit length, ending on a 512-bit block boundary.
- Fully back-pressurable output; flags the last beat of every 512-bit block for the compression stage.
- Sits between the message source and the SM3 expansion/compression core.

Parameters:
DW, 64, datapath width in bits; legal values 32, 64, 128.
BW, DW/8, bytes per beat (derived, not overridable).
BPB, 512/DW, beats per 512-bit block (derived).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
msg_inpt_d_i  in  DW  message beat; big-endian, first byte in MSBs
msg_inpt_vld_byte_i  in  BW  byte-valid mask; bit BW-1 marks the MSB byte; honoured only on the last beat
msg_inpt_vld_i  in  1  input beat valid
msg_inpt_lst_i  in  1  last beat of the message
msg_inpt_rdy_o  out  1  input ready
pad_otpt_d_o  out  DW  padded beat
pad_otpt_vld_o  out  1  output valid
pad_otpt_rdy_i  in  1  downstream ready
pad_otpt_blk_lst_o  out  1  beat is the last of a 512-bit block
pad_otpt_lst_o  out  1  beat is the last of the padded message

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except msg_inpt_rdy_o, which is 1. State IDLE. Byte counter and beat position are 0.
- Transfers:
  - Input transfer occurs on msg_inpt_vld_i & msg_inpt_rdy_o.
  - Output transfer occurs on pad_otpt_vld_o & pad_otpt_rdy_i.
  - Once pad_otpt_vld_o is high, it and all output data/flags hold stable until the transfer completes.
- Output stage: a single output register. It can load when it is empty or transferring this cycle (slot_free).
- Input ready: msg_inpt_rdy_o = slot_free & state ∈ {IDLE, DATA}. It is registered-equivalent combinational and has no dependence on msg_inpt_vld_i.
- Latency: an accepted input beat appears on the output the next cycle.
- Sustained throughput: 1 beat/cycle with pad_otpt_rdy_i held high.
- Byte counting:
  - Non-last beats count BW bytes; their vld_byte is ignored.
  - On the last beat, n = popcount(vld_byte). n ranges 0..BW, and the mask must be left-aligned; a non-contiguous mask gives undefined data but the block must not hang.
  - L = total message bytes, held in a 61-bit counter that wraps silently. Bit length = {L,3'b0}.
- Beat position: p counts output beats modulo BPB. pad_otpt_blk_lst_o = (p == BPB-1).
- Padded byte rule: byte at absolute index k is
  - msg byte if k < L;
  - 0x80 if k == L;
  - byte (k mod 64)-56 of the 64-bit length if k lies in the final 8 bytes of the final block;
  - 0x00 otherwise.
  - Final block end E = 64*ceil((L+9)/64).
- States:
  - IDLE: no message in flight. An accepted non-last beat goes to DATA. An accepted last beat goes to PAD, or to IDLE if that beat already reached E.
  - DATA: pass-through. An accepted non-last beat stays in DATA. An accepted last beat goes to PAD, or to IDLE if E is reached.
  - PAD: each time slot_free, generate the next beat per the padded byte rule and advance. When the beat covering byte E-1 loads, assert pad_otpt_lst_o on it and return to IDLE. Input is not accepted while in PAD.
- Last input beat content: valid bytes pass through, invalid bytes are forced to 0, and 0x80 goes at byte n if n < BW. If n == BW, the 0x80 goes in the first PAD beat.
- DW=128 only: length bytes can share a beat with message/0x80 bytes. A last beat landing at block beat 3 with n ≤ 7 completes the message in that same beat.
- Zero-length message: a last beat with n = 0 (allowed from IDLE) yields one block, 0x80 then zeros with length 0.
- End of message: pad_otpt_lst_o implies pad_otpt_blk_lst_o. On return to IDLE, L and p clear.
- A new message may be accepted the cycle after the last pad beat loads, subject to slot_free.
- Reset mid-operation: in-flight data is discarded and no partial output beat is presented after reset deasserts.

Test Plan:
1. DW=32, "abc": one beat 0x61626300, vld_byte 4'b1110, lst. Expect 16 beats: 0x61626380, 13×0x0, 0x00000000, 0x00000018. blk_lst and lst asserted on beat 16 only.
2. DW=64, 55-byte message (7 beats, last n=7). Expect exactly 8 beats (1 block). Beat 7 has 0x80 in its LSB byte; beat 8 = 0x00000000000001B8.
3. DW=64, 56-byte message (7 full beats). Expect 16 beats (2 blocks). Beat 8 = 0x8000000000000000; blk_lst on beats 8 and 16; lst on beat 16 only; beat 16 = 0x1C0.
4. DW=128, zero-length (lst, vld_byte=0). Expect 4 beats: 0x80 followed by zeros, last beat all zero (length 0); lst on beat 4.
5. DW=32, 64-byte message with pad_otpt_rdy_i randomly toggling ~50%. Expect 32 beats, output matching the no-backpressure run bit-for-bit, held stable while stalled, and msg_inpt_rdy_o low whenever the output is stalled.
6. Assert rst_n mid-PAD. Expect all outputs reset immediately and msg_inpt_rdy_o=1. A following "abc" message then produces the case-1 stream exactly.
